// File: rtl/four_and_pkg.sv
// Shared defaults and the saturating-increment helper for the four-input AND block.
package four_and_pkg;

  localparam int WIDTH_DEF = 1;
  localparam int CNT_W_DEF = 8;

  // Width-generic: callers zero-extend into 64 bits and pass their own all-ones ceiling.
  function automatic logic [63:0] sat_inc(input logic [63:0] cnt, input logic [63:0] max);
    return (cnt >= max) ? max : cnt + 64'd1;
  endfunction

endpackage

// File: rtl/and4_edge_det.sv
// Registers the AND result and flags per-bit 0->1 transitions aligned with it.
module and4_edge_det #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= '0;
      rise <= '0;
    end else begin
      q    <= d_in;
      rise <= d_in & ~q;
    end
  end

endmodule

// File: rtl/four_input_and_gate_a.sv
// Registered 4-input AND with all/any flags, rise pulses and a saturating hit counter.
// Define FOUR_INPUT_AND_GATE_A_SYNC_EN to add a 2-flop synchronizer on every input.
module four_input_and_gate_a
  import four_and_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic             e_all,
  output logic             e_any,
  output logic [WIDTH-1:0] e_rise,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam logic [63:0] CNT_MAX = {64{1'b1}} >> (64 - CNT_W);

  logic [WIDTH-1:0] a_s, b_s, c_s, d_s;

`ifdef FOUR_INPUT_AND_GATE_A_SYNC_EN
  logic [WIDTH-1:0] a_p0, b_p0, c_p0, d_p0;
  logic [WIDTH-1:0] a_p1, b_p1, c_p1, d_p1;

  // Synchronizer stages p0 -> p1
  always_ff @(posedge clk) begin
    if (rst) begin
      a_p0 <= '0; b_p0 <= '0; c_p0 <= '0; d_p0 <= '0;
      a_p1 <= '0; b_p1 <= '0; c_p1 <= '0; d_p1 <= '0;
    end else begin
      a_p0 <= a;    b_p0 <= b;    c_p0 <= c;    d_p0 <= d;
      a_p1 <= a_p0; b_p1 <= b_p0; c_p1 <= c_p0; d_p1 <= d_p0;
    end
  end

  assign a_s = a_p1;
  assign b_s = b_p1;
  assign c_s = c_p1;
  assign d_s = d_p1;
`else
  assign a_s = a;
  assign b_s = b;
  assign c_s = c;
  assign d_s = d;
`endif

  logic [WIDTH-1:0] and_p;
  assign and_p = a_s & b_s & c_s & d_s;

  and4_edge_det #(.WIDTH(WIDTH)) u_edge_det (
    .clk  (clk),
    .rst  (rst),
    .d_in (and_p),
    .q    (e),
    .rise (e_rise)
  );

  // Flags reduce the value being loaded, so they line up with e
  always_ff @(posedge clk) begin
    if (rst) begin
      e_all <= 1'b0;
      e_any <= 1'b0;
    end else begin
      e_all <= &and_p;
      e_any <= |and_p;
    end
  end

  logic [63:0] cnt_wide;
  logic [63:0] cnt_next;
  logic        cnt_unused;

  always_comb begin
    cnt_wide              = '0;
    cnt_wide[CNT_W-1:0]   = hit_cnt;
    cnt_next              = sat_inc(cnt_wide, CNT_MAX);
  end

  assign cnt_unused = &{1'b0, cnt_next};

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt <= '0;
    end else if (e_all) begin
      hit_cnt <= cnt_next[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_four_input_and_gate_a.sv
// Randomized and directed bench for four_input_and_gate_a against a cycle-level reference model.
module tb_four_input_and_gate_a;

  localparam int W     = 4;
  localparam int CW    = 8;
  localparam int CMAX  = (1 << CW) - 1;
`ifdef FOUR_INPUT_AND_GATE_A_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  a = '0, b = '0, c = '0, d = '0;
  logic [W-1:0]  e, e_rise;
  logic          e_all, e_any;
  logic [CW-1:0] hit_cnt;

  four_input_and_gate_a #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
    .e       (e),
    .e_all   (e_all),
    .e_any   (e_any),
    .e_rise  (e_rise),
    .hit_cnt (hit_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: inputs delayed S cycles, then the spec's per-cycle rules
  logic [W-1:0] pipe[$];
  logic [W-1:0] m_e, m_rise;
  logic         m_all, m_any;
  int           m_cnt;

  task automatic model_step(input logic r, input logic [W-1:0] ia, ib, ic, id);
    logic [W-1:0] nv;
    if (r) begin
      pipe.delete();
      for (int i = 0; i < S; i++) pipe.push_back('0);
      m_e = '0; m_rise = '0; m_all = 1'b0; m_any = 1'b0; m_cnt = 0;
    end else begin
      pipe.push_back(ia & ib & ic & id);
      nv = pipe.pop_front();
      if (m_all && m_cnt < CMAX) m_cnt = m_cnt + 1;
      m_rise = nv & ~m_e;
      m_e    = nv;
      m_all  = (nv == {W{1'b1}});
      m_any  = (nv != '0);
    end
  endtask

  task automatic tick(input logic r, input logic [W-1:0] ia, ib, ic, id);
    rst = r; a = ia; b = ib; c = ic; d = id;
    @(posedge clk);
    model_step(r, ia, ib, ic, id);
    @(negedge clk);
    check("e", e, m_e);
    check("e_all", e_all, m_all);
    check("e_any", e_any, m_any);
    check("e_rise", e_rise, m_rise);
    check("hit_cnt", hit_cnt, m_cnt);
  endtask

  localparam logic [W-1:0] ONES = '1;
  localparam logic [W-1:0] ZERO = '0;

  initial begin
    int rises;
    int lat;
    logic [3:0] v;
    logic [W-1:0] ra, rb, rc, rd;

    @(negedge clk);

    // Reset held 2 cycles with all inputs high
    tick(1'b1, ONES, ONES, ONES, ONES);
    tick(1'b1, ONES, ONES, ONES, ONES);
    check("rst_e", e, 0);
    check("rst_all", e_all, 0);
    check("rst_rise", e_rise, 0);
    check("rst_cnt", hit_cnt, 0);

    // Truth table, bit pattern replicated across all lanes
    for (int i = 0; i < 16; i++) begin
      v = i[3:0];
      tick(1'b0, {W{v[3]}}, {W{v[2]}}, {W{v[1]}}, {W{v[0]}});
    end
    rises = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, ZERO, ZERO, ZERO, ZERO);
      if (e_rise != '0) rises++;
    end
    check("tt_cnt", hit_cnt, 1);

    // Long hold: saturation and a single rise pulse
    rises = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1'b0, ONES, ONES, ONES, ONES);
      if (e_rise != '0) rises++;
    end
    check("sat_cnt", hit_cnt, CMAX);
    check("rise_once", rises, 1);

    // Mixed lanes
    for (int i = 0; i < S + 1; i++) tick(1'b0, 4'b1111, 4'b1010, 4'b1110, 4'b1011);
    check("mix_e", e, 4'b1010);
    check("mix_any", e_any, 1);
    check("mix_all", e_all, 0);

    // Mid-count reset at hit_cnt = 10
    tick(1'b1, ZERO, ZERO, ZERO, ZERO);
    for (int i = 0; i < 40 && hit_cnt != 10; i++) tick(1'b0, ONES, ONES, ONES, ONES);
    check("pre_rst_cnt", hit_cnt, 10);
    tick(1'b1, ONES, ONES, ONES, ONES);
    check("mid_rst_e", e, 0);
    check("mid_rst_flags", {e_all, e_any, e_rise}, 0);
    check("mid_rst_cnt", hit_cnt, 0);
    for (int i = 0; i < S + 2; i++) tick(1'b0, ONES, ONES, ONES, ONES);
    check("restart_cnt", hit_cnt, 1);

    // Input-to-e latency
    tick(1'b1, ZERO, ZERO, ZERO, ZERO);
    for (int i = 0; i < 3; i++) tick(1'b0, ZERO, ZERO, ZERO, ZERO);
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      tick(1'b0, ONES, ONES, ONES, ONES);
      if (lat == 0 && e == ONES) lat = i;
    end
    check("latency", lat, S + 1);

    // Randomized traffic, inputs biased toward all-ones so e_all occurs
    for (int i = 0; i < 400; i++) begin
      ra = ($urandom_range(0, 3) != 0) ? ONES : W'($urandom);
      rb = ($urandom_range(0, 3) != 0) ? ONES : W'($urandom);
      rc = ($urandom_range(0, 3) != 0) ? ONES : W'($urandom);
      rd = ($urandom_range(0, 3) != 0) ? ONES : W'($urandom);
      tick($urandom_range(0, 39) == 0, ra, rb, rc, rd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/four_input_and_gate_a.md
Name: four_input_and_gate_a

Overview:
- Clocked 4-input AND block: bitwise AND of four equal-width input vectors, registered to a single output vector.
- Adds status outputs: all-ones flag, any-ones flag, per-bit rising-edge pulses and a saturating hit counter.
- Sits as a leaf gating/qualification element; drives downstream enable logic and status registers.

Parameters:
- WIDTH, 1, bit width of each data input and of e (min 1).
- CNT_W, 8, width of hit counter (min 1).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c  input  WIDTH  operand C.
- d  input  WIDTH  operand D.
- e  output  WIDTH  registered a & b & c & d.
- e_all  output  1  registered; 1 when every bit of the new e is 1.
- e_any  output  1  registered; 1 when any bit of the new e is 1.
- e_rise  output  WIDTH  one-cycle pulse per bit when that e bit goes 0->1.
- hit_cnt  output  CNT_W  saturating count of cycles with e_all = 1.

Interface (already decided): one clock; reset is synchronous and active-high (clk, rst).

Behaviour:
- Reset: rst sampled high at a rising clk edge clears e, e_all, e_any, e_rise and hit_cnt to 0. rst overrides all other updates in that cycle.
- e: e <= a & b & c & d, bitwise, each rising edge. Latency 1 cycle; no combinational input-to-output path.
- e_all: e_all <= &(a & b & c & d), same cycle as e. It is the reduction of the value being loaded into e, not the old e.
- e_any: e_any <= |(a & b & c & d), same timing as e_all.
- e_rise[i]: 1 for exactly one cycle, in the cycle after e[i] changes from 0 to 1. Computed as new_e[i] & ~e[i] at the clock edge, so it is registered and aligned with e.
- After reset, e is 0, so a first cycle with e[i] = 1 produces an e_rise[i] pulse.
- hit_cnt: increments by 1 on each rising edge where e_all is 1 (the registered value). Saturates at 2^CNT_W - 1 and holds there; no wrap.
- Mid-operation reset: all outputs are 0 on the cycle after the reset edge. Counting resumes from 0 once rst is low.
- X/Z on inputs are not filtered; the behaviour follows from the AND.

Optional Feature:
- Macro: FOUR_INPUT_AND_GATE_A_SYNC_EN.
- Defined:
  - a, b, c and d each pass through a 2-flop synchronizer, reset to 0 by rst.
  - Input-to-e latency becomes 3 cycles.
  - All derived outputs shift by the same 2 cycles.
- Undefined: inputs go straight to the AND; latency 1 cycle.

Decomposition:
- Package four_and_pkg:
  - localparam defaults WIDTH_DEF = 1 and CNT_W_DEF = 8.
  - Function sat_inc(cnt) returning cnt + 1, clamped at all-ones.
- One sub-module, and4_edge_det:
  - Parameter WIDTH.
  - Ports: clk, rst, d_in[WIDTH], q[WIDTH], rise[WIDTH].
  - Registers the AND result and produces the rise pulses.
- The top level holds the AND, the e_all/e_any flags, the counter and the optional synchronizer.

Test Plan:
- Reset: hold rst = 1 for 2 cycles with a = b = c = d = 1 -> e = 0, e_all = 0, e_rise = 0, hit_cnt = 0.
- Exhaustive truth table (WIDTH = 1): step {a,b,c,d} 0000..1111, one value per cycle. The sequence matches the binary count where a toggles every 8 steps, b every 4, c every 2 and d every step.
  - e = 1 only for the 1111 step, one cycle later.
  - e_rise pulses once at that point.
  - hit_cnt ends at 1.
- Hold a = b = c = d = 1 for 300 cycles (CNT_W = 8) -> hit_cnt reaches 255 and stays there; e_rise pulses only once.
- WIDTH = 4, with a = 4'b1111, b = 4'b1010, c = 4'b1110, d = 4'b1011 -> e = 4'b1010, e_any = 1, e_all = 0.
- Assert rst for one cycle mid-count (hit_cnt = 10) -> all outputs 0 on the next cycle; the count restarts from 0.
- FOUR_INPUT_AND_GATE_A_SYNC_EN defined: drive 1111 at cycle 0 -> e = 1 first seen 3 cycles after the input change.
